// File: rtl/sass_rx2_if.sv
// SASS receiver bundle: serial line in, received word with strobe and status out.
interface sass_rx2_if #(
  parameter int DATA_L = 14
);
  logic              s;
  logic [DATA_L-1:0] data;
  logic              avl;
  logic              perr;
  logic              ferr;
  logic              busy;

  modport master (output s, input data, avl, perr, ferr, busy);
  modport slave  (input s, output data, avl, perr, ferr, busy);
endinterface

// File: rtl/sass_rx2.sv
// Second-generation SASS single-wire receiver: synchronised, 3-sample voted,
// start-validated, optional parity, stop-bit framing check and stuck-low lockout.
module sass_rx2 #(
  parameter int DATA_L     = 14,
  parameter int CLK_F      = 50_000_000,
  parameter int RANGE      = 1_000_000,
  parameter int T          = 300,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst,
  sass_rx2_if.slave bus
);
  localparam longint T_DL = (longint'(CLK_F) * longint'(T)) / longint'(RANGE);
  localparam int T_D = int'(T_DL);
  localparam int CW  = $clog2(T_D);
  localparam int IW  = (DATA_L > 1) ? $clog2(DATA_L) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(T_D - 1);
  localparam logic [CW-1:0] SMP0     = CW'(T_D / 2 - 1);
  localparam logic [CW-1:0] SMP1     = CW'(T_D / 2);
  localparam logic [CW-1:0] SMP2     = CW'(T_D / 2 + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_L - 1);
  localparam logic          PAR_ON   = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic          ODD_BIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  generate
    if (T_D < 4) begin : g_bad_t_d
      $error("sass_rx2: bit duration T_D must be at least 4 clocks");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              s_meta_r;
  logic              s_q_r;
  logic              s_prev_r;
  logic [CW-1:0]     cnt_r;
  logic [IW-1:0]     idx_r;
  logic              smp0_r;
  logic              smp1_r;
  logic [DATA_L-1:0] shift_r;
  logic              par_r;
  logic [DATA_L-1:0] data_r;
  logic              avl_r;
  logic              perr_r;
  logic              ferr_r;
  logic              busy_r;
  logic              emit_s;

  // The third sample is the live s_q, so the vote settles on the cycle at SMP2.
  wire logic decision_s = (smp0_r & smp1_r) | (smp0_r & s_q_r) | (smp1_r & s_q_r);
  wire logic at_dec_s   = (cnt_r == SMP2);
  wire logic wrap_s     = (cnt_r == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and end-of-frame publish strobe
  always_comb begin
    next_state_s = state_r;
    emit_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!s_q_r && s_prev_r) next_state_s = ST_START;
        else                    next_state_s = ST_IDLE;
      end
      ST_START: begin
        if (at_dec_s && decision_s) next_state_s = ST_IDLE;
        else if (wrap_s)            next_state_s = ST_DATA;
        else                        next_state_s = ST_START;
      end
      ST_DATA: begin
        if (wrap_s && (idx_r == IDX_LAST)) next_state_s = PAR_ON ? ST_PARITY : ST_STOP;
        else                               next_state_s = ST_DATA;
      end
      ST_PARITY: begin
        if (wrap_s) next_state_s = ST_STOP;
        else        next_state_s = ST_PARITY;
      end
      ST_STOP: begin
        // Leave mid-stop-bit on a good stop so a back-to-back start edge is seen.
        if (at_dec_s) begin
          emit_s       = 1'b1;
          next_state_s = decision_s ? ST_IDLE : ST_HOLD;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      ST_HOLD: begin
        if (s_q_r) next_state_s = ST_IDLE;
        else       next_state_s = ST_HOLD;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Synchroniser, bit timing, sampling, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta_r <= 1'b1;
      s_q_r    <= 1'b1;
      s_prev_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      idx_r    <= {IW{1'b0}};
      smp0_r   <= 1'b0;
      smp1_r   <= 1'b0;
      shift_r  <= {DATA_L{1'b0}};
      par_r    <= 1'b0;
      data_r   <= {DATA_L{1'b0}};
      avl_r    <= 1'b0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      s_meta_r <= bus.s;
      s_q_r    <= s_meta_r;
      s_prev_r <= s_q_r;

      if ((state_r == ST_IDLE) || (state_r == ST_HOLD) || wrap_s) cnt_r <= {CW{1'b0}};
      else                                                        cnt_r <= cnt_r + CW'(1);

      if (cnt_r == SMP0) smp0_r <= s_q_r;
      if (cnt_r == SMP1) smp1_r <= s_q_r;

      if (state_r == ST_START)                idx_r <= {IW{1'b0}};
      else if ((state_r == ST_DATA) && wrap_s) idx_r <= idx_r + IW'(1);

      if ((state_r == ST_DATA) && at_dec_s)   shift_r[idx_r] <= decision_s;
      if ((state_r == ST_PARITY) && at_dec_s) par_r <= decision_s;

      avl_r <= emit_s;
      if (emit_s) begin
        data_r <= shift_r;
        perr_r <= PAR_ON & ((^shift_r) ^ par_r ^ ODD_BIT);
        ferr_r <= ~decision_s;
      end
      busy_r <= (next_state_s != ST_IDLE);
    end
  end

  assign bus.data = data_r;
  assign bus.avl  = avl_r;
  assign bus.perr = perr_r;
  assign bus.ferr = ferr_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_sass_rx2.sv
// Bench for sass_rx2: directed vector table, hand-built corner sequences and
// randomised lines checked against a frame-level reference model.
module tb_sass_rx2;
  localparam int TD = 8;
  localparam int DL = 8;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       busy_nx;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    bit         sel;
    bit         par;
    bit         stop_v;
    int         stop_n;
    logic [7:0] exp_d;
    bit         exp_perr;
    bit         exp_ferr;
    bit         exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   line_q[$];
  ev_t  got0[$];
  ev_t  got1[$];
  ev_t  exp_q[$];
  bit   pend0, pend1;
  int   last_busy0;

  sass_rx2_if #(.DATA_L(DL)) if0 ();
  sass_rx2_if #(.DATA_L(DL)) if1 ();

  sass_rx2 #(.DATA_L(DL), .CLK_F(1_000_000), .RANGE(1_000_000), .T(8),
             .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  sass_rx2 #(.DATA_L(DL), .CLK_F(1_000_000), .RANGE(1_000_000), .T(8),
             .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every avl pulse with its edge number and the busy level one cycle later
  always @(negedge clk) begin
    if (pend0 && got0.size() > 0) got0[got0.size()-1].busy_nx = if0.busy;
    if (pend1 && got1.size() > 0) got1[got1.size()-1].busy_nx = if1.busy;
    pend0 = if0.avl;
    pend1 = if1.avl;
    if (if0.avl) got0.push_back('{cyc, if0.data, if0.perr, if0.ferr, 1'b0});
    if (if1.avl) got1.push_back('{cyc, if1.data, if1.perr, if1.ferr, 1'b0});
    if (if0.busy) last_busy0 = cyc;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_bits(input bit v, input int n);
    for (int i = 0; i < n; i++) line_q.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] d, input bit pe, input bit par,
                           input bit stop_v, input int stop_n);
    add_bits(1'b0, TD);
    for (int i = 0; i < DL; i++) add_bits(d[i], TD);
    if (pe) add_bits(par, TD);
    add_bits(stop_v, stop_n);
  endtask

  // Edge base samples line_q[0]; line_q[k] is seen by edge base+k.
  task automatic drive(input bit sel, output int base);
    @(posedge clk); #1;
    got0.delete();
    got1.delete();
    last_busy0 = -1;
    base = cyc + 1;
    foreach (line_q[k]) begin
      if (sel) if1.s = line_q[k];
      else     if0.s = line_q[k];
      @(posedge clk); #1;
    end
    if0.s = 1'b1;
    if1.s = 1'b1;
  endtask

  function automatic bit ln(input int i);
    if (i < 0 || i >= line_q.size()) return 1'b1;
    return line_q[i];
  endfunction

  // Majority of the three line samples taken mid-bit for bit b of a frame starting at e0
  function automatic bit vote(input int e0, input int b);
    int n = 0;
    for (int j = 0; j < 3; j++) n += int'(ln(e0 + b * TD + TD / 2 + j));
    return (n >= 2);
  endfunction

  // Frame-level reference: scan the line for high-to-low starts and decode whole frames
  task automatic model_run(input bit pe, input int base);
    int nb = DL + int'(pe) + 2;
    int k = 0;
    int e0, a;
    logic [7:0] w;
    bit par, stp;
    ev_t ev;
    exp_q.delete();
    forever begin
      e0 = k;
      while (e0 < line_q.size() && !(ln(e0) == 1'b0 && ln(e0 - 1) == 1'b1)) e0++;
      if (e0 >= line_q.size()) break;
      if (vote(e0, 0)) begin
        k = e0 + 3 + TD / 2;
        continue;
      end
      for (int i = 0; i < DL; i++) w[i] = vote(e0, i + 1);
      par = pe ? vote(e0, DL + 1) : 1'b0;
      stp = vote(e0, nb - 1);
      a = e0 + 4 + (nb - 1) * TD + TD / 2;
      ev.edge_n  = base + a;
      ev.data    = w;
      ev.perr    = pe ? ((^w) ^ par) : 1'b0;
      ev.ferr    = !stp;
      ev.busy_nx = 1'b0;
      exp_q.push_back(ev);
      k = a - 1;
      if (!stp) begin
        while (k < line_q.size() && ln(k) == 1'b0) k++;
        k++;
      end
    end
  endtask

  task automatic compare_events(input bit sel, input int base, input string tag);
    ev_t g[$];
    model_run(sel, base);
    if (sel) g = got1;
    else     g = got0;
    check({tag, "_count"}, g.size(), exp_q.size());
    for (int i = 0; i < g.size() && i < exp_q.size(); i++) begin
      check({tag, "_edge"}, g[i].edge_n, exp_q[i].edge_n);
      check({tag, "_data"}, g[i].data, exp_q[i].data);
      check({tag, "_perr"}, g[i].perr, exp_q[i].perr);
      check({tag, "_ferr"}, g[i].ferr, exp_q[i].ferr);
    end
  endtask

  initial begin
    int   base;
    int   nfr;
    int   pos;
    bit   sel;
    ev_t  g[$];
    vec_t vt[8];

    rst = 1'b0;
    if0.s = 1'b1;
    if1.s = 1'b1;
    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, TD,     8'hA5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, TD,     8'h3C, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, TD,     8'h3C, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 3 * TD, 8'h5A, 1'b0, 1'b1, 1'b1};
    vt[4] = '{8'h01, 1'b0, 1'b0, 1'b1, TD,     8'h01, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'h80, 1'b1, 1'b0, 1'b1, TD,     8'h80, 1'b1, 1'b0, 1'b0};
    vt[6] = '{8'h81, 1'b1, 1'b0, 1'b1, TD,     8'h81, 1'b0, 1'b0, 1'b0};
    vt[7] = '{8'hFF, 1'b0, 1'b0, 1'b0, TD,     8'hFF, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_data", if0.data, 8'h00);
    check("reset_avl",  if0.avl,  1'b0);
    check("reset_perr", if1.perr, 1'b0);
    check("reset_ferr", if0.ferr, 1'b0);
    check("reset_busy", if0.busy, 1'b0);
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      line_q.delete();
      add_bits(1'b1, 4);
      add_frame(vt[v].d, vt[v].sel, vt[v].par, vt[v].stop_v, vt[v].stop_n);
      add_bits(1'b1, 12 * TD);
      drive(vt[v].sel, base);
      if (vt[v].sel) g = got1;
      else           g = got0;
      check("vec_count", g.size(), 1);
      if (g.size() > 0) begin
        check("vec_data",    g[0].data,    vt[v].exp_d);
        check("vec_perr",    g[0].perr,    vt[v].exp_perr);
        check("vec_ferr",    g[0].ferr,    vt[v].exp_ferr);
        check("vec_busy_nx", g[0].busy_nx, vt[v].exp_busy);
        check("vec_latency", g[0].edge_n - base - 4, 4 + (DL + int'(vt[v].sel) + 1) * TD + TD / 2);
      end
      compare_events(vt[v].sel, base, "vec_model");
    end

    // Two-clock low glitch: false start, no word, busy drops at the start decision
    line_q.delete();
    add_bits(1'b1, 4);
    add_bits(1'b0, 2);
    add_bits(1'b1, 12 * TD);
    drive(1'b0, base);
    check("glitch_count", got0.size(), 0);
    check("glitch_busy_last", last_busy0 - base - 4, 7);

    // One-clock spike on the middle sample of data bit 3 of a 0x00 frame
    line_q.delete();
    add_bits(1'b1, 4);
    add_frame(8'h00, 1'b0, 1'b0, 1'b1, TD);
    add_bits(1'b1, 12 * TD);
    line_q[4 + 4 * TD + TD / 2 + 1] = 1'b1;
    drive(1'b0, base);
    check("spike_count", got0.size(), 1);
    if (got0.size() > 0) check("spike_data", got0[0].data, 8'h00);

    // Back-to-back frames with a stop bit of exactly one bit time
    line_q.delete();
    add_bits(1'b1, 4);
    add_frame(8'h11, 1'b0, 1'b0, 1'b1, TD);
    add_frame(8'hEE, 1'b0, 1'b0, 1'b1, TD);
    add_bits(1'b1, 12 * TD);
    drive(1'b0, base);
    check("b2b_count", got0.size(), 2);
    if (got0.size() == 2) begin
      check("b2b_data0", got0[0].data, 8'h11);
      check("b2b_data1", got0[1].data, 8'hEE);
      check("b2b_spacing", got0[1].edge_n - got0[0].edge_n, 80);
    end

    // Reset in data bit 4 with the line low, released while still low
    line_q.delete();
    add_bits(1'b1, 4);
    add_bits(1'b0, TD);
    add_bits(1'b1, 4 * TD);
    add_bits(1'b0, 3);
    drive(1'b0, base);
    if0.s = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_data", if0.data, 8'h00);
    check("rst_mid_avl",  if0.avl,  1'b0);
    check("rst_mid_ferr", if0.ferr, 1'b0);
    check("rst_mid_busy", if0.busy, 1'b0);
    check("rst_mid_no_avl", got0.size(), 0);
    rst = 1'b1;
    line_q.delete();
    add_bits(1'b0, 2);
    add_bits(1'b1, 5 * TD);
    add_frame(8'h7F, 1'b0, 1'b0, 1'b1, TD);
    add_bits(1'b1, 12 * TD);
    drive(1'b0, base);
    check("rst_after_count", got0.size(), 1);
    if (got0.size() > 0) begin
      check("rst_after_data", got0[0].data, 8'h7F);
      check("rst_after_ferr", got0[0].ferr, 1'b0);
    end

    // Randomised frames, gaps, stop levels and line glitches against the model
    for (int r = 0; r < 30; r++) begin
      sel = 1'($urandom_range(0, 1));
      nfr = $urandom_range(1, 3);
      line_q.delete();
      add_bits(1'b1, 4 + $urandom_range(0, 7));
      for (int f = 0; f < nfr; f++) begin
        if ($urandom_range(0, 3) != 0)
          add_frame(8'($urandom), sel, 1'($urandom), 1'b1, TD + $urandom_range(0, TD - 1));
        else
          add_frame(8'($urandom), sel, 1'($urandom), 1'b0, TD + $urandom_range(0, 2 * TD));
        add_bits(1'b1, $urandom_range(0, 2 * TD));
      end
      if ($urandom_range(0, 1) != 0) begin
        for (int gl = 0; gl < 2; gl++) begin
          pos = 4 + $urandom_range(0, line_q.size() - 5);
          line_q[pos] = ~line_q[pos];
        end
      end
      add_bits(1'b1, 12 * TD);
      drive(sel, base);
      compare_events(sel, base, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/sass_rx2.md
Name: sass_rx2

Overview:
- Second-generation SASS single-wire serial receiver.
- Adds the following over the first generation:
  - 2-FF input synchroniser.
  - 3-sample majority voting per bit.
  - Start-bit validation (false-start rejection).
  - Optional even/odd parity.
  - Stop-bit framing check.
  - Lockout on stuck-low line.
- Sits between the SASS line and the TMR voter/consumer. It presents each received word with a one-cycle avl strobe and error flags.

Parameters:
- DATA_L, 14, data bits per frame (>=1).
- CLK_F, 50_000_000, clock frequency in Hz.
- RANGE, 1_000_000, time-unit divisor.
- T, 300, bit duration in units of 1/RANGE s. T_D = CLK_F*T/RANGE clocks; T_D<4 is an elaboration error.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (only when PARITY_EN=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s  in  1  SASS line, idle high, asynchronous to clk.
- data  out  DATA_L  last received word; LSB is the first bit on the line.
- avl  out  1  one-cycle strobe: data/perr/ferr updated.
- perr  out  1  parity error of the word flagged by avl (0 if PARITY_EN=0).
- ferr  out  1  stop bit sampled low for the word flagged by avl.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - Outputs: data=0, avl=0, perr=0, ferr=0, busy=0.
  - Internals: state=IDLE, both sync FFs=1, s_prev=0, counters=0.
  - A frame in progress is discarded with no avl.
- Frame on the line: start(0), DATA_L data bits LSB first, parity bit if PARITY_EN, stop(1); each bit lasts T_D clocks. NB = DATA_L + PARITY_EN + 2.
- Sync: s_q is s delayed 2 clocks; s_prev is s_q delayed 1 clock. All logic uses s_q.
- Counters:
  - cnt counts 0..T_D-1 within a bit and wraps to 0 at T_D-1, where the bit index advances.
  - Counter widths use $clog2.
- Samples: taken at cnt = T_D/2-1, T_D/2 and T_D/2+1 (integer division). The bit value is the majority of the three, decided at cnt = T_D/2+1; the third sample is used combinationally.
- States:
  - IDLE: s_q=0 and s_prev=1 -> START, cnt=0. A low line without a preceding high is ignored.
  - START: decision=1 -> IDLE (false start, no avl). Decision=0 -> continue; at cnt wrap -> DATA, idx=0.
  - DATA: at the decision, store the bit into shift[idx]. At cnt wrap, idx++; after bit DATA_L-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: store the parity bit; at cnt wrap -> STOP.
  - STOP: at the decision, register the outputs:
    - data = shift, avl = 1.
    - perr = (XOR of data bits ^ parity bit ^ PARITY_ODD) != 0.
    - ferr = ~decision.
    - Then: stop=1 -> IDLE immediately (mid-stop-bit, so back-to-back frames are accepted); stop=0 -> HOLD.
  - HOLD: wait for s_q=1 -> IDLE. busy stays high.
- avl is high for exactly one cycle per completed frame.
- data, perr and ferr hold their values until the next avl. They are not cleared by false starts.
- Latency: let edge 0 be the first rising edge that samples s low. avl is high in the cycle following edge 4 + (NB-1)*T_D + T_D/2. With T_D=8, DATA_L=8, no parity, that is edge 80.
- The line is ignored in every state except at sample points and for edge detection in IDLE/HOLD.

Test Plan (CLK_F=RANGE=1_000_000, T=8 -> T_D=8, DATA_L=8 unless stated):
1. Clean frame 0xA5, PARITY_EN=0 -> avl for one cycle after edge 80, data=0xA5, perr=0, ferr=0, busy low in the following cycle.
2. PARITY_EN=1, PARITY_ODD=0, frame 0x3C with parity bit 1 (wrong) -> data=0x3C, perr=1, ferr=0. Repeat with parity bit 0 -> perr=0.
3. Frame 0x5A with stop bit held low for 3*T_D, then idle, then frame 0x01 -> first avl has data=0x5A, ferr=1. No start is accepted while the line is low. Second avl has data=0x01, ferr=0.
4. Glitches:
   - Line low for 2 clocks, then high -> no avl; busy falls by edge 8.
   - One-clock inverted spike on data bit 3 at cnt=T_D/2 of frame 0x00 -> data=0x00.
5. Two back-to-back frames 0x11 and 0xEE, stop bit exactly T_D -> two avl pulses, 80 cycles apart, with correct data.
6. Reset asserted during data bit 4 while the line is held low through release -> outputs 0, no avl. After the line goes high then low, frame 0x7F is received normally.
